// File: rtl/zap_wb_arbiter_n_if.sv
// zap_wb_arbiter_n_if: bus bundle between N cache-side masters, the arbiter and the
// registered external Wishbone port. The slave modport is the arbiter's view.
interface zap_wb_arbiter_n_if #(
    parameter int unsigned NUM_MASTERS = 3
);
    localparam int unsigned N = NUM_MASTERS;

    // Master-side requests (combinational *_nxt style), master k in slice k
    logic [N-1:0]    i_m_cyc_nxt;
    logic [N-1:0]    i_m_stb_nxt;
    logic [N-1:0]    i_m_wen_nxt;
    logic [4*N-1:0]  i_m_sel_nxt;
    logic [32*N-1:0] i_m_dat_nxt;
    logic [32*N-1:0] i_m_adr_nxt;
    logic [3*N-1:0]  i_m_cti_nxt;

    // Responses routed back to the owning master
    logic [N-1:0]    o_m_ack;
    logic [N-1:0]    o_m_err;
    logic [N-1:0]    o_grant;

    // Muxed bus, combinational
    logic            o_wb_cyc_nxt;
    logic            o_wb_stb_nxt;
    logic            o_wb_wen_nxt;
    logic [3:0]      o_wb_sel_nxt;
    logic [31:0]     o_wb_dat_nxt;
    logic [31:0]     o_wb_adr_nxt;
    logic [2:0]      o_wb_cti_nxt;

    // Muxed bus, registered
    logic            o_wb_cyc;
    logic            o_wb_stb;
    logic            o_wb_wen;
    logic [3:0]      o_wb_sel;
    logic [31:0]     o_wb_dat;
    logic [31:0]     o_wb_adr;
    logic [2:0]      o_wb_cti;

    // Slave responses
    logic            i_wb_ack;
    logic            i_wb_err;

    modport slave (
        input  i_m_cyc_nxt, i_m_stb_nxt, i_m_wen_nxt, i_m_sel_nxt,
        input  i_m_dat_nxt, i_m_adr_nxt, i_m_cti_nxt,
        input  i_wb_ack, i_wb_err,
        output o_m_ack, o_m_err, o_grant,
        output o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt, o_wb_sel_nxt,
        output o_wb_dat_nxt, o_wb_adr_nxt, o_wb_cti_nxt,
        output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );

    modport master (
        output i_m_cyc_nxt, i_m_stb_nxt, i_m_wen_nxt, i_m_sel_nxt,
        output i_m_dat_nxt, i_m_adr_nxt, i_m_cti_nxt,
        output i_wb_ack, i_wb_err,
        input  o_m_ack, o_m_err, o_grant,
        input  o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt, o_wb_sel_nxt,
        input  o_wb_dat_nxt, o_wb_adr_nxt, o_wb_cti_nxt,
        input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );
endinterface

// File: rtl/zap_wb_arbiter_n.sv
// zap_wb_arbiter_n: N-master Wishbone B3 arbiter. Ownership is held for a whole bus cycle,
// the bus mux follows the next grant so a new owner's first beat has no bubble, and an
// optional watchdog (TIMEOUT > 0) ends stalled beats with a synthetic ACK+ERR.
// Build option: define ZAP_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// highest-index requester wins.
module zap_wb_arbiter_n #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned TIMEOUT     = 0
) (
    input logic               i_clk,
    input logic               i_reset,
    zap_wb_arbiter_n_if.slave bus
);
    localparam int unsigned N = NUM_MASTERS;

    logic [N-1:0] r_grant;
    logic [N-1:0] w_grant_nxt;
    logic [N-1:0] w_pick;
    logic         w_owner_cyc;
    logic         w_boundary;
    logic         w_release;
    logic         w_wd_hit;

    logic         r_wb_cyc, r_wb_stb, r_wb_wen;
    logic [3:0]   r_wb_sel;
    logic [31:0]  r_wb_dat, r_wb_adr;
    logic [2:0]   r_wb_cti;

    logic         w_wb_cyc, w_wb_stb, w_wb_wen;
    logic [3:0]   w_wb_sel;
    logic [31:0]  w_wb_dat, w_wb_adr;
    logic [2:0]   w_wb_cti;

    assign w_owner_cyc = |(bus.i_m_cyc_nxt & r_grant);
    assign w_boundary  = !r_wb_stb || bus.i_wb_ack || w_wd_hit;
    // An owner whose cycle is not on the bus yet (o_wb_cyc low) holds nothing, so a fresh
    // set of requests after idle or reset is arbitrated even if it includes the owner.
    assign w_release   = w_boundary && (!w_owner_cyc || !r_wb_cyc);
    assign w_grant_nxt = (w_release && (|bus.i_m_cyc_nxt)) ? w_pick : r_grant;

`ifdef ZAP_WB_ARB_ROUND_ROBIN_EN
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] w_owner_idx;
    logic [IW-1:0] w_scan;
    logic          w_found;

    // Round robin: first requester scanning upward from owner+1; the owner comes last.
    always_comb begin
        w_owner_idx = '0;
        w_scan      = '0;
        w_found     = 1'b0;
        w_pick      = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (r_grant[k]) w_owner_idx = IW'(k);
        end
        for (int off = 1; off <= int'(N); off++) begin
            w_scan = IW'((int'(w_owner_idx) + off) % int'(N));
            if (!w_found && bus.i_m_cyc_nxt[w_scan]) begin
                w_pick[w_scan] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end
`else
    // Fixed priority: the highest requesting index wins.
    always_comb begin
        w_pick = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (bus.i_m_cyc_nxt[k]) begin
                w_pick    = '0;
                w_pick[k] = 1'b1;
            end
        end
    end
`endif

    // Bus mux driven by the next grant (one-hot AND-OR select).
    always_comb begin
        w_wb_cyc = 1'b0;
        w_wb_stb = 1'b0;
        w_wb_wen = 1'b0;
        w_wb_sel = '0;
        w_wb_dat = '0;
        w_wb_adr = '0;
        w_wb_cti = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (w_grant_nxt[k]) begin
                w_wb_cyc = bus.i_m_cyc_nxt[k];
                w_wb_stb = bus.i_m_stb_nxt[k];
                w_wb_wen = bus.i_m_wen_nxt[k];
                w_wb_sel = bus.i_m_sel_nxt[4*k +: 4];
                w_wb_dat = bus.i_m_dat_nxt[32*k +: 32];
                w_wb_adr = bus.i_m_adr_nxt[32*k +: 32];
                w_wb_cti = bus.i_m_cti_nxt[3*k +: 3];
            end
        end
    end

    // Register grant and bus; reset parks the bus idle with EOB and hands grant to master 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant  <= {{(N-1){1'b0}}, 1'b1};
            r_wb_cyc <= 1'b0;
            r_wb_stb <= 1'b0;
            r_wb_wen <= 1'b0;
            r_wb_sel <= '0;
            r_wb_dat <= '0;
            r_wb_adr <= '0;
            r_wb_cti <= 3'b111;
        end else begin
            r_grant  <= w_grant_nxt;
            r_wb_cyc <= w_wb_cyc;
            r_wb_stb <= w_wb_stb;
            r_wb_wen <= w_wb_wen;
            r_wb_sel <= w_wb_sel;
            r_wb_dat <= w_wb_dat;
            r_wb_adr <= w_wb_adr;
            r_wb_cti <= w_wb_cti;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] r_wd_cnt;

        // Fires on the TIMEOUT-th consecutive stalled STB cycle.
        assign w_wd_hit = r_wb_stb && !bus.i_wb_ack && (r_wd_cnt == CW'(TIMEOUT - 1));

        // Count stalled STB cycles; any ACK, idle STB or watchdog hit restarts the count.
        always_ff @(posedge i_clk) begin
            if (i_reset || !r_wb_stb || bus.i_wb_ack || w_wd_hit) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end else begin : g_no_wd
        assign w_wd_hit = 1'b0;
    end

`ifndef SYNTHESIS
    // A slave raising ERR without ACK is a protocol violation.
    always_ff @(posedge i_clk) begin
        if (!i_reset && bus.i_wb_err && !bus.i_wb_ack) begin
            $fatal(1, "zap_wb_arbiter_n: i_wb_err asserted without i_wb_ack");
        end
    end
`endif

    assign bus.o_m_ack      = r_grant & {N{r_wb_stb & (bus.i_wb_ack | w_wd_hit)}};
    assign bus.o_m_err      = r_grant & {N{r_wb_stb & (bus.i_wb_err | w_wd_hit)}};
    assign bus.o_grant      = r_grant;

    assign bus.o_wb_cyc_nxt = w_wb_cyc;
    assign bus.o_wb_stb_nxt = w_wb_stb;
    assign bus.o_wb_wen_nxt = w_wb_wen;
    assign bus.o_wb_sel_nxt = w_wb_sel;
    assign bus.o_wb_dat_nxt = w_wb_dat;
    assign bus.o_wb_adr_nxt = w_wb_adr;
    assign bus.o_wb_cti_nxt = w_wb_cti;

    assign bus.o_wb_cyc     = r_wb_cyc;
    assign bus.o_wb_stb     = r_wb_stb;
    assign bus.o_wb_wen     = r_wb_wen;
    assign bus.o_wb_sel     = r_wb_sel;
    assign bus.o_wb_dat     = r_wb_dat;
    assign bus.o_wb_adr     = r_wb_adr;
    assign bus.o_wb_cti     = r_wb_cti;
endmodule

// File: tb/tb_zap_wb_arbiter_n.sv
// tb_zap_wb_arbiter_n: table vectors, directed burst/watchdog sequences and random traffic,
// all checked against a cycle-level reference model of ownership, routing and watchdog.
module tb_zap_wb_arbiter_n;
    localparam int unsigned N       = 3;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zap_wb_arbiter_n_if #(.NUM_MASTERS(N)) bus ();

    zap_wb_arbiter_n #(.NUM_MASTERS(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Master-side stimulus
    logic        t_cyc[N];
    logic        t_stb[N];
    logic        t_wen[N];
    logic [3:0]  t_sel[N];
    logic [2:0]  t_cti[N];
    logic [31:0] t_dat[N];
    logic [31:0] t_adr[N];

    // Reference model: current owner, registered bus, consecutive stalled STB cycles
    int          m_owner;
    int          m_stall;
    logic        m_cyc, m_stb, m_wen;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;
    logic [31:0] m_dat, m_adr;
    int          e_owner;
    logic        e_hit;
    logic        l_ack;

    typedef struct packed {
        logic        rst;
        logic [2:0]  cyc;
        logic        ack;
        logic        err;
        logic [2:0]  e_grant;
        logic [2:0]  e_ack;
        logic [2:0]  e_err;
        logic        e_stb;
        logic [31:0] e_adr;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [73:0] pack_bus(input logic c, input logic s, input logic w,
                                             input logic [3:0] sel, input logic [2:0] cti,
                                             input logic [31:0] adr, input logic [31:0] dat);
        return {c, s, w, sel, cti, adr, dat};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ack, input logic err);
        rst          = r;
        bus.i_wb_ack = ack;
        bus.i_wb_err = err;
        for (int k = 0; k < int'(N); k++) begin
            bus.i_m_cyc_nxt[k]         = t_cyc[k];
            bus.i_m_stb_nxt[k]         = t_stb[k];
            bus.i_m_wen_nxt[k]         = t_wen[k];
            bus.i_m_sel_nxt[4*k +: 4]  = t_sel[k];
            bus.i_m_cti_nxt[3*k +: 3]  = t_cti[k];
            bus.i_m_dat_nxt[32*k +: 32] = t_dat[k];
            bus.i_m_adr_nxt[32*k +: 32] = t_adr[k];
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_stall = 0;
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_wen   = 1'b0;
        m_sel   = '0;
        m_cti   = 3'b111;
        m_dat   = '0;
        m_adr   = '0;
    endtask

    // Drive one cycle's inputs, predict from the rules and compare outputs before the edge.
    task automatic apply(input logic r, input logic ack, input logic err);
        logic       open, found;
        logic [2:0] exp_grant, exp_ack, exp_err;
        drive(r, ack, err);
        l_ack = ack;
        #1;
        e_hit   = (TIMEOUT != 0) && m_stb && !ack && (m_stall + 1 == int'(TIMEOUT));
        open    = (!m_stb || ack || e_hit) && (!t_cyc[m_owner] || !m_cyc);
        e_owner = m_owner;
        found   = 1'b0;
        if (open) begin
`ifdef ZAP_WB_ARB_ROUND_ROBIN_EN
            for (int off = 1; off <= int'(N); off++) begin
                if (!found && t_cyc[(m_owner + off) % int'(N)]) begin
                    e_owner = (m_owner + off) % int'(N);
                    found   = 1'b1;
                end
            end
`else
            for (int j = int'(N) - 1; j >= 0; j--) begin
                if (!found && t_cyc[j]) begin
                    e_owner = j;
                    found   = 1'b1;
                end
            end
`endif
        end
        exp_grant = 3'(1 << m_owner);
        exp_ack   = (m_stb && (ack || e_hit)) ? exp_grant : 3'b000;
        exp_err   = (m_stb && (err || e_hit)) ? exp_grant : 3'b000;
        check("grant", 128'(bus.o_grant), 128'(exp_grant));
        check("m_ack", 128'(bus.o_m_ack), 128'(exp_ack));
        check("m_err", 128'(bus.o_m_err), 128'(exp_err));
        check("wb_reg",
              128'(pack_bus(bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_wen, bus.o_wb_sel,
                            bus.o_wb_cti, bus.o_wb_adr, bus.o_wb_dat)),
              128'(pack_bus(m_cyc, m_stb, m_wen, m_sel, m_cti, m_adr, m_dat)));
        check("wb_nxt",
              128'(pack_bus(bus.o_wb_cyc_nxt, bus.o_wb_stb_nxt, bus.o_wb_wen_nxt,
                            bus.o_wb_sel_nxt, bus.o_wb_cti_nxt, bus.o_wb_adr_nxt,
                            bus.o_wb_dat_nxt)),
              128'(pack_bus(t_cyc[e_owner], t_stb[e_owner], t_wen[e_owner], t_sel[e_owner],
                            t_cti[e_owner], t_adr[e_owner], t_dat[e_owner])));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_stall = (m_stb && !l_ack && !e_hit) ? m_stall + 1 : 0;
            m_cyc   = t_cyc[e_owner];
            m_stb   = t_stb[e_owner];
            m_wen   = t_wen[e_owner];
            m_sel   = t_sel[e_owner];
            m_cti   = t_cti[e_owner];
            m_dat   = t_dat[e_owner];
            m_adr   = t_adr[e_owner];
            m_owner = e_owner;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic set_cyc(input logic [2:0] v);
        for (int k = 0; k < int'(N); k++) begin
            t_cyc[k] = v[k];
            t_stb[k] = v[k];
        end
    endtask

    initial begin
        // {rst, cyc, ack, err, exp grant, exp ack, exp err, exp stb, exp adr}
        tbl[0] = '{1'b0, 3'b011, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h000};
        tbl[1] = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 32'h100};
        tbl[2] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 32'h100};
        tbl[3] = '{1'b0, 3'b100, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h100};
        tbl[4] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 3'b100, 3'b100, 1'b1, 32'h200};
        tbl[5] = '{1'b0, 3'b001, 1'b1, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 32'h200};
        tbl[6] = '{1'b0, 3'b101, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 32'h000};
        tbl[7] = '{1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 32'h000};
        tbl[8] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h000};

        for (int k = 0; k < int'(N); k++) begin
            t_cyc[k] = 1'b0;
            t_stb[k] = 1'b0;
            t_wen[k] = (k == 1);
            t_sel[k] = 4'(k + 1);
            t_cti[k] = 3'(k + 1);
            t_dat[k] = 32'hD000 + 32'(k);
            t_adr[k] = 32'h100 * 32'(k);
        end
        l_ack = 1'b0;
        e_hit = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        model_reset();
        e_owner = 0;
        @(negedge clk);

        // Table vectors starting from reset
        for (int i = 0; i < 9; i++) begin
            set_cyc(tbl[i].cyc);
            apply(tbl[i].rst, tbl[i].ack, tbl[i].err);
            check("tbl_grant", 128'(bus.o_grant), 128'(tbl[i].e_grant));
            check("tbl_ack", 128'(bus.o_m_ack), 128'(tbl[i].e_ack));
            check("tbl_err", 128'(bus.o_m_err), 128'(tbl[i].e_err));
            check("tbl_stb", 128'(bus.o_wb_stb), 128'(tbl[i].e_stb));
            check("tbl_adr", 128'(bus.o_wb_adr), 128'(tbl[i].e_adr));
            if (tbl[i].rst == 1'b0 && i == 8) begin
                check("tbl_reset_cti", 128'(bus.o_wb_cti), 128'(3'b111));
            end
            tick();
        end

        // Master 0 four-beat burst; master 2 requests from beat 2 and waits
        set_cyc(3'b001);
        t_adr[0] = 32'h1000; t_cti[0] = 3'b010;
        apply(1'b0, 1'b0, 1'b0);
        tick();
        for (int b = 1; b <= 4; b++) begin
            t_cyc[2] = 1'b1; t_stb[2] = 1'b1; t_adr[2] = 32'h2000; t_cti[2] = 3'b111;
            if (b < 4) begin
                t_adr[0] = 32'h1000 + 32'(4 * b);
                t_cti[0] = (b == 3) ? 3'b111 : 3'b010;
            end else begin
                t_cyc[0] = 1'b0; t_stb[0] = 1'b0;
            end
            apply(1'b0, 1'b1, 1'b0);
            check("burst_hold", 128'(bus.o_grant), 128'(3'b001));
            check("burst_ack", 128'(bus.o_m_ack), 128'(3'b001));
            if (b == 4) check("burst_handover_nxt", 128'(bus.o_wb_adr_nxt), 128'(32'h2000));
            tick();
        end
        set_cyc(3'b000);
        apply(1'b0, 1'b1, 1'b0);
        check("m2_grant", 128'(bus.o_grant), 128'(3'b100));
        check("m2_first_beat", 128'(bus.o_wb_adr), 128'(32'h2000));
        tick();

        // Watchdog: slave never ACKs master 1's beat
        set_cyc(3'b010);
        t_adr[1] = 32'h300;
        apply(1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            t_cyc[1] = (i < int'(TIMEOUT));
            t_stb[1] = t_cyc[1];
            apply(1'b0, 1'b0, 1'b0);
            check("wd_ack", 128'(bus.o_m_ack), 128'((i == int'(TIMEOUT)) ? 3'b010 : 3'b000));
            check("wd_err", 128'(bus.o_m_err), 128'((i == int'(TIMEOUT)) ? 3'b010 : 3'b000));
            tick();
        end
        apply(1'b0, 1'b0, 1'b0);
        check("wd_after_stb", 128'(bus.o_wb_stb), 128'(1'b0));
        check("wd_after_ack", 128'(bus.o_m_ack), 128'(3'b000));
        tick();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            logic ack, err;
            for (int k = 0; k < int'(N); k++) begin
                if ($urandom_range(3) == 0) t_cyc[k] = ~t_cyc[k];
                t_stb[k] = t_cyc[k] & ($urandom_range(3) != 0);
                t_wen[k] = 1'($urandom);
                t_sel[k] = 4'($urandom);
                t_cti[k] = 3'($urandom);
                t_dat[k] = $urandom;
                t_adr[k] = $urandom;
            end
            ack = ($urandom_range(2) == 0);
            err = ack & ($urandom_range(3) == 0);
            apply(($urandom_range(99) == 0), ack, err);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
